lane_gearbox: RTL and testbench

Per-lane rate adapter downstream of the 16-lane symbol distributor. Accepts one full LANE_WIDTH lane word per `i_sync` strobe, buffers up to DEPTH words, and emits each as LANE_WIDTH/OUT_WIDTH consecutive OUT_WIDTH-bit slices, LSB slice first, under a valid/ready handshake. The 16 instances, one per lane, feed the PMA-side serializers.

---
 rtl/lane_gearbox_if.sv | 23 ++
 rtl/lane_gearbox.sv | 117 +++++++++++
 tb/tb_lane_gearbox.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_gearbox_if.sv
// Output slice stream of lane_gearbox: data, valid, ready and start-of-word flag.
interface lane_gearbox_if #(
    parameter int OUT_WIDTH = 136
);
    logic [OUT_WIDTH-1:0] o_data;
    logic                 o_valid;
    logic                 o_sof;
    logic                 i_ready;

    modport master (
        output o_data,
        output o_valid,
        output o_sof,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        input  o_sof,
        output i_ready
    );
endinterface

// File: rtl/lane_gearbox.sv
// Per-lane gearbox: buffers lane words, streams them as LSB-first slices.
// Optional drop counter is built when LANE_GBX_DROP_CNT_EN is defined.
module lane_gearbox #(
    parameter int LANE_WIDTH = 1360,
    parameter int OUT_WIDTH  = 136,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANE_WIDTH-1:0] i_lane,
    input  logic                  i_sync,
    output logic                  o_ready,
    lane_gearbox_if.master        out_if,
    output logic                  o_overflow,
    output logic [15:0]           o_drop_count
);
    localparam int N  = LANE_WIDTH / OUT_WIDTH;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                  state_q, state_d;
    logic [LANE_WIDTH-1:0]   mem_q [DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [SW-1:0]           slice_q, slice_d;
    logic                    ovf_q, ovf_d;
    logic                    valid, xfer, pop, push, drop;
    logic [N-1:0][OUT_WIDTH-1:0] head;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        head  = mem_q[rd_ptr_q];
        valid = (state_q == STREAM);
        xfer  = valid && out_if.i_ready;
        pop   = xfer && (slice_q == SW'(N - 1));
        // A full buffer still accepts when the head leaves this cycle
        push  = i_sync && ((count_q < CW'(DEPTH)) ||
                           ((count_q == CW'(DEPTH)) && pop));
        drop  = i_sync && !push;
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        slice_d  = slice_q;
        ovf_d    = ovf_q | drop;
        if (push) wr_ptr_d = inc_ptr(wr_ptr_q);
        if (xfer) slice_d = pop ? '0 : slice_q + SW'(1);
        if (pop) rd_ptr_d = inc_ptr(rd_ptr_q);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        unique case (state_q)
            IDLE:    if (count_d != '0) state_d = STREAM;
            STREAM:  if (count_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            slice_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            slice_q  <= slice_d;
            ovf_q    <= ovf_d;
            if (push) mem_q[wr_ptr_q] <= i_lane;
        end
    end

    assign o_ready        = (count_q < CW'(DEPTH));
    assign o_overflow     = ovf_q;
    assign out_if.o_valid = valid;
    assign out_if.o_sof   = valid && (slice_q == '0);
    assign out_if.o_data  = valid ? head[slice_q] : '0;

`ifdef LANE_GBX_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drop_cnt_q <= '0;
        else      drop_cnt_q <= drop_cnt_d;
    end

    assign o_drop_count = drop_cnt_q;
`else
    assign o_drop_count = '0;
`endif
endmodule

// File: tb/tb_lane_gearbox.sv
// Randomized and directed bench for lane_gearbox with a word-queue reference
// model and a slice scoreboard checked by an independent output monitor.
module tb_lane_gearbox;
    localparam int LW    = 1360;
    localparam int OW    = 136;
    localparam int DEPTH = 2;
    localparam int N     = LW / OW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [LW-1:0] i_lane = '0;
    logic          i_sync = 1'b0;
    logic          o_ready;
    logic          o_overflow;
    logic [15:0]   o_drop_count;

    lane_gearbox_if #(.OUT_WIDTH(OW)) bus ();

    lane_gearbox #(
        .LANE_WIDTH(LW),
        .OUT_WIDTH (OW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_lane      (i_lane),
        .i_sync      (i_sync),
        .o_ready     (o_ready),
        .out_if      (bus),
        .o_overflow  (o_overflow),
        .o_drop_count(o_drop_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model: accepted words in order, slices consumed of the head
    logic [LW-1:0] mq [$];
    int            mslice = 0;
    bit            m_ovf = 1'b0;
    int            m_drop = 0;

    // scoreboard of expected output slices
    logic [OW-1:0] sb_d [$];
    bit            sb_sof [$];

    task automatic chk(input string name, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_word();
        logic [LW-1:0] w = '0;
        for (int i = 0; i < LW / 32 + 1; i++) w = {w[LW-33:0], 32'($urandom)};
        return w;
    endfunction

    function automatic logic [LW-1:0] pat_word();
        logic [LW-1:0] w = '0;
        for (int j = 0; j < N; j++)
            for (int b = 0; b < OW / 4; b++) w[j*OW + b*4 +: 4] = 4'(j);
        return w;
    endfunction

    task automatic model_edge(input bit s, input logic [LW-1:0] w, input bit r);
        bit xfer, fin, push;
        xfer = (mq.size() != 0) && r;
        fin  = xfer && (mslice == N - 1);
        push = s && ((mq.size() < DEPTH) || (mq.size() == DEPTH && fin));
        if (s && !push) begin
            m_ovf = 1'b1;
`ifdef LANE_GBX_DROP_CNT_EN
            if (m_drop != 16'hFFFF) m_drop++;
`endif
        end
        if (xfer) begin
            if (fin) begin
                void'(mq.pop_front());
                mslice = 0;
            end else begin
                mslice++;
            end
        end
        if (push) begin
            mq.push_back(w);
            for (int j = 0; j < N; j++) begin
                sb_d.push_back(w[j*OW +: OW]);
                sb_sof.push_back(j == 0);
            end
        end
    endtask

    task automatic check_state();
        bit v;
        v = (mq.size() != 0);
        chk("o_valid", OW'(bus.o_valid), OW'(v));
        chk("o_sof", OW'(bus.o_sof), OW'(v && mslice == 0));
        chk("o_ready", OW'(o_ready), OW'(mq.size() < DEPTH));
        chk("o_overflow", OW'(o_overflow), OW'(m_ovf));
        chk("o_drop_count", OW'(o_drop_count), OW'(m_drop));
    endtask

    task automatic step(input bit s, input logic [LW-1:0] w, input bit r);
        i_sync      = s;
        i_lane      = w;
        bus.i_ready = r;
        model_edge(s, w, r);
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic clear_model();
        mq.delete();
        sb_d.delete();
        sb_sof.delete();
        mslice = 0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_o_data", bus.o_data, '0);
        chk("rst_o_valid", OW'(bus.o_valid), '0);
        chk("rst_o_sof", OW'(bus.o_sof), '0);
        chk("rst_o_ready", OW'(o_ready), OW'(1));
        chk("rst_o_overflow", OW'(o_overflow), '0);
        chk("rst_o_drop_count", OW'(o_drop_count), '0);
    endtask

    // output monitor: pops the scoreboard on every transfer, checks stalls
    bit            stall = 1'b0;
    logic [OW-1:0] hold_d;
    logic          hold_sof;

    always @(negedge clk) begin
        if (!rst) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_data", bus.o_data, hold_d);
                chk("hold_valid", OW'(bus.o_valid), OW'(1));
                chk("hold_sof", OW'(bus.o_sof), OW'(hold_sof));
            end
            if (bus.o_valid && bus.i_ready) begin
                if (sb_d.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_slice: got %h expected none",
                             bus.o_data);
                end else begin
                    chk("slice_data", bus.o_data, sb_d.pop_front());
                    chk("slice_sof", OW'(bus.o_sof), OW'(sb_sof.pop_front()));
                end
            end
            stall    = bus.o_valid && !bus.i_ready;
            hold_d   = bus.o_data;
            hold_sof = bus.o_sof;
        end
    end

    initial begin
        logic [LW-1:0] w0, w1, w2, pw;
        int guard;
        bus.i_ready = 1'b0;
        pw = pat_word();
        w0 = rand_word();
        w1 = rand_word();
        w2 = rand_word();

        @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_state();

        // single word, ready held high
        step(1'b1, pw, 1'b1);
        repeat (12) step(1'b0, '0, 1'b1);

        // backpressure 1,0,0,...
        step(1'b1, pw, 1'b1);
        for (int i = 0; i < 35; i++) step(1'b0, '0, (i % 3) == 2);
        repeat (12) step(1'b0, '0, 1'b1);

        // back-to-back words ten cycles apart
        step(1'b1, w0, 1'b1);
        repeat (9) step(1'b0, '0, 1'b1);
        step(1'b1, w1, 1'b1);
        repeat (14) step(1'b0, '0, 1'b1);

        // fill and drop with the sink stalled
        step(1'b1, w0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, w1, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, w2, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0);
        repeat (25) step(1'b0, '0, 1'b1);

        // reset asserted while slice 4 is presented
        step(1'b1, w0, 1'b1);
        guard = 0;
        while (!(mq.size() != 0 && mslice == 4) && guard < 20) begin
            step(1'b0, '0, 1'b1);
            guard++;
        end
        chk("reach_slice4", OW'(guard < 20), OW'(1));
        rst = 1'b0;
        #1;
        check_reset_outputs();
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b1, pw, 1'b1);
        repeat (12) step(1'b0, '0, 1'b1);

        // push on final pop of a full buffer
        step(1'b1, w0, 1'b0);
        step(1'b1, w1, 1'b0);
        repeat (N - 1) step(1'b0, '0, 1'b1);
        step(1'b1, w2, 1'b1);
        repeat (25) step(1'b0, '0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 6) == 0, rand_word(),
                 $urandom_range(0, 3) != 0);
        repeat (3 * N + 5) step(1'b0, '0, 1'b1);
        @(negedge clk);
        chk("scoreboard_empty", OW'(sb_d.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
